rt_table_programmer: RTL and testbench



---
 rtl/rt_table_programmer.sv | 218 +++++++++++++++++++++
 tb/tb_rt_table_programmer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_table_programmer.sv
// Routing-table configuration sequencer: holds the router in program mode, writes streamed
// (flowID, entry) pairs one WEn strobe at a time, then brings the router live.
// Optional statistics ports (prog_count, prog_cycles) are enabled by defining RT_PROG_STATS_EN.
module rt_table_programmer #(
    parameter  int ID_BITS      = 4,
    parameter  int EXTRA        = 2,
    parameter  int RT_WIDTH     = 5,
    parameter  int MAX_ENTRIES  = 16,
    parameter  int SETUP_CYCLES = 2,
    parameter  int GAP_CYCLES   = 1,
    localparam int FLOW_BITS    = 2*ID_BITS + EXTRA,
    localparam int CNT_BITS     = $clog2(MAX_ENTRIES) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [FLOW_BITS-1:0] cfg_flowID,
    input  logic [RT_WIDTH-1:0]  cfg_entry,
    input  logic                 cfg_last,
    output logic                 ON,
    output logic                 PROG,
    output logic                 WEn,
    output logic                 REn,
    output logic [FLOW_BITS-1:0] rt_flowID,
    output logic [RT_WIDTH-1:0]  rt_entry,
    output logic                 busy,
    output logic                 done,
`ifdef RT_PROG_STATS_EN
    output logic                 overflow,
    output logic [CNT_BITS-1:0]  prog_count,
    output logic [15:0]          prog_cycles
`else
    output logic                 overflow
`endif
);

    localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_CFG,
        WRITE,
        GAP,
        LIVE
    } state_t;

    state_t                 state_reg, state_next;
    logic [SETUP_W-1:0]     setup_cnt_reg, setup_cnt_next;
    logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
    logic [CNT_BITS-1:0]    count_reg, count_next;
    logic                   last_reg, last_next;
    logic                   on_reg, on_next;
    logic                   prog_reg, prog_next;
    logic                   wen_reg, wen_next;
    logic                   ready_reg, ready_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   overflow_reg, overflow_next;
    logic [FLOW_BITS-1:0]   flow_reg, flow_next;
    logic [RT_WIDTH-1:0]    entry_reg, entry_next;
    logic                   start_accept;

    // A start only counts when no session is running (IDLE or LIVE).
    assign start_accept = start && !busy_reg && ((state_reg == IDLE) || (state_reg == LIVE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            setup_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
            count_reg     <= '0;
            last_reg      <= 1'b0;
            on_reg        <= 1'b0;
            prog_reg      <= 1'b0;
            wen_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            flow_reg      <= '0;
            entry_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            setup_cnt_reg <= setup_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            count_reg     <= count_next;
            last_reg      <= last_next;
            on_reg        <= on_next;
            prog_reg      <= prog_next;
            wen_reg       <= wen_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            overflow_reg  <= overflow_next;
            flow_reg      <= flow_next;
            entry_reg     <= entry_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        setup_cnt_next = setup_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        count_next     = count_reg;
        last_next      = last_reg;
        on_next        = on_reg;
        prog_next      = prog_reg;
        wen_next       = 1'b0;
        ready_next     = ready_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        overflow_next  = overflow_reg;
        flow_next      = flow_reg;
        entry_next     = entry_reg;

        if (start_accept) begin
            // Take the router offline in the same update that enters program mode.
            state_next     = SETUP;
            setup_cnt_next = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            on_next        = 1'b0;
            done_next      = 1'b0;
            prog_next      = 1'b1;
            busy_next      = 1'b1;
            ready_next     = 1'b0;
        end else begin
            case (state_reg)
                SETUP: begin
                    if (setup_cnt_reg == SETUP_W'(SETUP_CYCLES - 1)) begin
                        state_next = WAIT_CFG;
                        ready_next = 1'b1;
                    end else begin
                        setup_cnt_next = setup_cnt_reg + SETUP_W'(1);
                    end
                end
                WAIT_CFG: begin
                    if (cfg_valid && ready_reg) begin
                        state_next = WRITE;
                        wen_next   = 1'b1;
                        ready_next = 1'b0;
                        flow_next  = cfg_flowID;
                        entry_next = cfg_entry;
                        last_next  = cfg_last;
                    end
                end
                WRITE: begin
                    state_next   = GAP;
                    count_next   = count_reg + CNT_BITS'(1);
                    gap_cnt_next = '0;
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
                        if (last_reg || (count_reg == CNT_BITS'(MAX_ENTRIES))) begin
                            // A full table without a closing last flag is reported as overflow.
                            state_next    = LIVE;
                            overflow_next = !last_reg;
                            prog_next     = 1'b0;
                            on_next       = 1'b1;
                            done_next     = 1'b1;
                            busy_next     = 1'b0;
                            ready_next    = 1'b0;
                        end else begin
                            state_next = WAIT_CFG;
                            ready_next = 1'b1;
                        end
                    end else begin
                        gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                    end
                end
                IDLE, LIVE: begin
                    ready_next = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                    on_next    = 1'b0;
                    prog_next  = 1'b0;
                    ready_next = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_reg;
    assign ON        = on_reg;
    assign PROG      = prog_reg;
    assign WEn       = wen_reg;
    assign REn       = 1'b0;
    assign rt_flowID = flow_reg;
    assign rt_entry  = entry_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;

`ifdef RT_PROG_STATS_EN
    logic [15:0] prog_cycles_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prog_cycles_reg <= '0;
        end else if (start_accept) begin
            prog_cycles_reg <= '0;
        end else if (busy_reg && (prog_cycles_reg != 16'hFFFF)) begin
            prog_cycles_reg <= prog_cycles_reg + 16'd1;
        end
    end

    assign prog_count  = count_reg;
    assign prog_cycles = prog_cycles_reg;
`endif

endmodule

// File: tb/tb_rt_table_programmer.sv
// Directed bench for rt_table_programmer: written pairs are queued when driven and
// checked against rt_flowID/rt_entry whenever WEn is observed.
module tb_rt_table_programmer;

    logic       clock;
    logic       reset;
    logic       start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] cfg_flowID;
    logic [4:0] cfg_entry;
    logic       cfg_last;
    logic       ON;
    logic       PROG;
    logic       WEn;
    logic       REn;
    logic [9:0] rt_flowID;
    logic [4:0] rt_entry;
    logic       busy;
    logic       done;
    logic       overflow;
`ifdef RT_PROG_STATS_EN
    logic [4:0]  prog_count;
    logic [15:0] prog_cycles;
`endif

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          wen_count = 0;
    bit          mon_en    = 0;
    logic [14:0] exp_q[$];
    int          wen_cyc[$];
    logic [14:0] exp_pair;

    rt_table_programmer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_flowID (cfg_flowID),
        .cfg_entry  (cfg_entry),
        .cfg_last   (cfg_last),
        .ON         (ON),
        .PROG       (PROG),
        .WEn        (WEn),
        .REn        (REn),
        .rt_flowID  (rt_flowID),
        .rt_entry   (rt_entry),
        .busy       (busy),
        .done       (done),
`ifdef RT_PROG_STATS_EN
        .overflow   (overflow),
        .prog_count (prog_count),
        .prog_cycles(prog_cycles)
`else
        .overflow   (overflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every WEn strobe must match the oldest driven pair.
    always @(negedge clock) begin
        if (mon_en) begin
            check("on_prog_exclusive", 32'(ON & PROG), 32'h0);
            if (WEn) begin
                wen_count++;
                wen_cyc.push_back(cyc);
                check("wen_needs_prog", 32'(PROG), 32'h1);
                if (exp_q.size() == 0) begin
                    check("wen_unexpected", 32'(WEn), 32'h0);
                end else begin
                    exp_pair = exp_q.pop_front();
                    check("wr_pair", 32'({rt_flowID, rt_entry}), 32'(exp_pair));
                end
                $display("write #%0d cycle %0d flowID=%h entry=%b", wen_count, cyc, rt_flowID, rt_entry);
            end
        end
    end

    // Present one pair (cfg_valid left high) and return on the negedge after the transfer.
    task automatic send(input logic [9:0] f, input logic [4:0] e, input logic last);
        int w;
        cfg_flowID = f;
        cfg_entry  = e;
        cfg_last   = last;
        cfg_valid  = 1'b1;
        w = 0;
        while (!cfg_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("ready_wait", 32'(cfg_ready), 32'h1);
        if (cfg_ready) begin
            exp_q.push_back({f, e});
            @(negedge clock);
        end
    endtask

    task automatic wait_on(output int on_cycle);
        int w;
        w = 0;
        while (!ON && w < 20) begin
            @(negedge clock);
            w++;
        end
        on_cycle = cyc;
        check("on_wait", 32'(ON), 32'h1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        logic [9:0] bf [3];
        logic [4:0] be [3];
        int         w0;
        int         on_cycle;

        bf = '{10'h101, 10'h2A5, 10'h3FF};
        be = '{5'b01010, 5'b11111, 5'b00001};

        reset      = 1'b0;
        start      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_last   = 1'b0;
        cfg_flowID = '0;
        cfg_entry  = '0;

        // Reset asserted between edges must clear outputs at once.
        #3 reset = 1'b1;
        #1;
        check("rst_ON", 32'(ON), 32'h0);
        check("rst_PROG", 32'(PROG), 32'h0);
        check("rst_WEn", 32'(WEn), 32'h0);
        check("rst_REn", 32'(REn), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_flowID", 32'(rt_flowID), 32'h0);
        check("rst_entry", 32'(rt_entry), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_PROG", 32'(PROG), 32'h0);
        check("idle_ON", 32'(ON), 32'h0);
        check("idle_ready", 32'(cfg_ready), 32'h0);
        $display("reset phase complete at cycle %0d", cyc);

        // Single entry with last.
        pulse_start();
        check("s1_PROG", 32'(PROG), 32'h1);
        check("s1_busy", 32'(busy), 32'h1);
        check("s1_ON", 32'(ON), 32'h0);
        check("s1_ready_setup0", 32'(cfg_ready), 32'h0);
        @(negedge clock);
        check("s1_ready_setup1", 32'(cfg_ready), 32'h0);
        @(negedge clock);
        check("s1_ready_after_setup", 32'(cfg_ready), 32'h1);
        send(10'h012, 5'b10011, 1'b1);
        cfg_valid = 1'b0;
        check("s1_WEn", 32'(WEn), 32'h1);
        check("s1_flowID", 32'(rt_flowID), 32'h012);
        check("s1_entry", 32'(rt_entry), 32'h13);
        check("s1_ready_write", 32'(cfg_ready), 32'h0);
        @(negedge clock);
        check("s1_gap_WEn", 32'(WEn), 32'h0);
        check("s1_gap_ON", 32'(ON), 32'h0);
        check("s1_gap_flowID", 32'(rt_flowID), 32'h012);
        @(negedge clock);
        check("s1_live_ON", 32'(ON), 32'h1);
        check("s1_live_PROG", 32'(PROG), 32'h0);
        check("s1_live_done", 32'(done), 32'h1);
        check("s1_live_busy", 32'(busy), 32'h0);
`ifdef RT_PROG_STATS_EN
        check("s1_prog_count", 32'(prog_count), 32'h1);
        check("s1_prog_cycles", 32'(prog_cycles), 32'h5);
`endif
        $display("single-entry session live at cycle %0d", cyc);

        // Reprogram from LIVE, with a second start during SETUP that must be ignored.
        start = 1'b1;
        @(negedge clock);
        check("rp_ON", 32'(ON), 32'h0);
        check("rp_PROG", 32'(PROG), 32'h1);
        check("rp_done", 32'(done), 32'h0);
        check("rp_busy", 32'(busy), 32'h1);
        @(negedge clock);
        start = 1'b0;
        check("rp_ready_setup", 32'(cfg_ready), 32'h0);
        @(negedge clock);
        check("rp_ready_on_time", 32'(cfg_ready), 32'h1);

        // Burst of three with cfg_valid held high.
        wen_cyc.delete();
        w0 = wen_count;
        for (int i = 0; i < 3; i++) begin
            send(bf[i], be[i], (i == 2));
        end
        cfg_valid = 1'b0;
        wait_on(on_cycle);
        check("b3_wen_count", 32'(wen_count - w0), 32'h3);
        check("b3_wen_records", 32'(wen_cyc.size()), 32'h3);
        if (wen_cyc.size() == 3) begin
            check("b3_spacing01", 32'(wen_cyc[1] - wen_cyc[0]), 32'h3);
            check("b3_spacing12", 32'(wen_cyc[2] - wen_cyc[1]), 32'h3);
            check("b3_on_latency", 32'(on_cycle - wen_cyc[2]), 32'h2);
        end
        check("b3_queue_empty", 32'(exp_q.size()), 32'h0);
        check("b3_overflow", 32'(overflow), 32'h0);
        $display("burst session live at cycle %0d", cyc);

        // Overflow: seventeen pairs, none marked last.
        w0 = wen_count;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send(10'(i * 37 + 5), 5'(i + 1), 1'b0);
        end
        cfg_flowID = 10'h3C3;
        cfg_entry  = 5'b10101;
        cfg_last   = 1'b0;
        cfg_valid  = 1'b1;
        wait_on(on_cycle);
        check("ov_flag", 32'(overflow), 32'h1);
        check("ov_done", 32'(done), 32'h1);
        check("ov_ready", 32'(cfg_ready), 32'h0);
        repeat (5) @(negedge clock);
        check("ov_wen_count", 32'(wen_count - w0), 32'h10);
        check("ov_ready_held", 32'(cfg_ready), 32'h0);
        check("ov_queue_empty", 32'(exp_q.size()), 32'h0);
        check("ov_sticky", 32'(overflow), 32'h1);
        cfg_valid = 1'b0;
        $display("overflow session live at cycle %0d", cyc);

        // Reset during GAP after two writes.
        pulse_start();
        check("mr_overflow_cleared", 32'(overflow), 32'h0);
        send(10'h0AA, 5'b00110, 1'b0);
        send(10'h155, 5'b11001, 1'b0);
        cfg_valid = 1'b0;
        @(negedge clock);
        check("mr_gap_PROG", 32'(PROG), 32'h1);
        check("mr_gap_busy", 32'(busy), 32'h1);
`ifdef RT_PROG_STATS_EN
        check("mr_prog_count_pre", 32'(prog_count), 32'h2);
`endif
        w0 = wen_count;
        #2 reset = 1'b1;
        #1;
        check("mr_ON", 32'(ON), 32'h0);
        check("mr_PROG", 32'(PROG), 32'h0);
        check("mr_WEn", 32'(WEn), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_ready", 32'(cfg_ready), 32'h0);
`ifdef RT_PROG_STATS_EN
        check("mr_prog_count_post", 32'(prog_count), 32'h0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("mr_no_more_wen", 32'(wen_count - w0), 32'h0);
        check("mr_idle_busy", 32'(busy), 32'h0);
        check("mr_idle_ON", 32'(ON), 32'h0);
        $display("mid-session reset settled at cycle %0d", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
